// File: rtl/uart_loader.sv
// Boot loader: receives a length-prefixed little-endian program image over UART,
// writes it into the instruction ROM, and holds the core in reset until done.
module uart_loader #(
  parameter int          CLK_DIV   = 434,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 4096
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        boot_en_i,
  input  logic        uart_rx_i,
  output logic        rom_cs_o,
  output logic        rom_we_o,
  output logic [3:0]  rom_wem_o,
  output logic [31:0] rom_addr_o,
  output logic [31:0] rom_data_o,
  output logic        core_rstn_o,
  output logic        load_done_o,
  output logic        load_err_o
);

  localparam int              CNT_W    = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLK_DIV/2 - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_st_e;
  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_WRITE, S_DONE, S_ERR} st_e;

  // ---------------- UART receiver ----------------
  rx_st_e           rx_st_q;
  logic             rx_meta_q, rx_sync_q, rx_prev_q;
  logic [CNT_W-1:0] rx_cnt_q;
  logic [2:0]       rx_bit_q;
  logic [7:0]       rx_sh_q;
  logic             byte_vld_q, frame_err_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_st_q     <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_sh_q     <= '0;
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_meta_q   <= uart_rx_i;
      rx_sync_q   <= rx_meta_q;
      rx_prev_q   <= rx_sync_q;
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
      case (rx_st_q)
        RX_IDLE: if (rx_prev_q && !rx_sync_q) begin
          rx_st_q  <= RX_START;
          rx_cnt_q <= HALF_CNT;
        end
        RX_START: begin
          if (rx_cnt_q == '0) begin
            // A line that is high again at mid start-bit was only a glitch
            if (rx_sync_q) rx_st_q <= RX_IDLE;
            else begin
              rx_st_q  <= RX_DATA;
              rx_cnt_q <= FULL_CNT;
              rx_bit_q <= '0;
            end
          end else rx_cnt_q <= rx_cnt_q - 1'b1;
        end
        RX_DATA: begin
          if (rx_cnt_q == '0) begin
            rx_sh_q  <= {rx_sync_q, rx_sh_q[7:1]};
            rx_cnt_q <= FULL_CNT;
            rx_bit_q <= rx_bit_q + 1'b1;
            if (rx_bit_q == 3'd7) rx_st_q <= RX_STOP;
          end else rx_cnt_q <= rx_cnt_q - 1'b1;
        end
        RX_STOP: begin
          if (rx_cnt_q == '0) begin
            if (rx_sync_q) byte_vld_q  <= 1'b1;
            else           frame_err_q <= 1'b1;
            rx_st_q <= RX_IDLE;
          end else rx_cnt_q <= rx_cnt_q - 1'b1;
        end
        default: rx_st_q <= RX_IDLE;
      endcase
    end
  end

  // ---------------- Word assembly + load FSM ----------------
  st_e         st_q;
  logic [31:0] word_q, rem_q;
  logic [1:0]  idx_q;
  logic [31:0] full_word;
  logic        accept, word_done;

  // rx_sh_q is stable on the byte_vld cycle, so it doubles as the received byte
  assign full_word = {rx_sh_q, word_q[31:8]};
  assign accept    = (st_q == S_LEN) || (st_q == S_DATA) || (st_q == S_WRITE);
  assign word_done = byte_vld_q && (idx_q == 2'd3);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_q        <= S_IDLE;
      word_q      <= '0;
      idx_q       <= '0;
      rem_q       <= '0;
      rom_cs_o    <= 1'b0;
      rom_we_o    <= 1'b0;
      rom_wem_o   <= 4'h0;
      rom_addr_o  <= BASE_ADDR;
      rom_data_o  <= '0;
      core_rstn_o <= 1'b0;
      load_done_o <= 1'b0;
      load_err_o  <= 1'b0;
    end else begin
      if (byte_vld_q && accept) begin
        word_q <= full_word;
        idx_q  <= idx_q + 1'b1;
      end
      case (st_q)
        S_IDLE: begin
          if (boot_en_i) st_q <= S_LEN;
          else begin
            st_q        <= S_DONE;
            load_done_o <= 1'b1;
            core_rstn_o <= 1'b1;
          end
        end
        S_LEN: begin
          if (frame_err_q) begin
            st_q       <= S_ERR;
            load_err_o <= 1'b1;
          end else if (word_done) begin
            if (full_word == '0) begin
              st_q        <= S_DONE;
              load_done_o <= 1'b1;
              core_rstn_o <= 1'b1;
            end else if (full_word > 32'(MAX_WORDS)) begin
              st_q       <= S_ERR;
              load_err_o <= 1'b1;
            end else begin
              st_q       <= S_DATA;
              rem_q      <= full_word;
              rom_addr_o <= BASE_ADDR;
            end
          end
        end
        S_DATA: begin
          if (frame_err_q) begin
            st_q       <= S_ERR;
            load_err_o <= 1'b1;
          end else if (word_done) begin
            st_q       <= S_WRITE;
            rom_cs_o   <= 1'b1;
            rom_we_o   <= 1'b1;
            rom_wem_o  <= 4'hF;
            rom_data_o <= full_word;
          end
        end
        S_WRITE: begin
          rom_cs_o   <= 1'b0;
          rom_we_o   <= 1'b0;
          rom_wem_o  <= 4'h0;
          rom_addr_o <= rom_addr_o + 32'd4;
          rem_q      <= rem_q - 1'b1;
          if (rem_q == 32'd1) begin
            st_q        <= S_DONE;
            load_done_o <= 1'b1;
            core_rstn_o <= 1'b1;
          end else st_q <= S_DATA;
        end
        S_DONE, S_ERR: st_q <= st_q;
        default: st_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// Randomized bench for uart_loader: serialises byte images onto the RX line and
// compares ROM writes and status against an image-level reference model.
module tb_uart_loader;
  localparam int          CLK_DIV = 4;
  localparam logic [31:0] BASE    = 32'h0000_0000;
  localparam int          MAXW    = 4096;

  logic        clk = 1'b0;
  logic        rstn;
  logic        boot_en = 1'b0;
  logic        rx = 1'b1;
  logic        rom_cs, rom_we, core_rstn, load_done, load_err;
  logic [3:0]  rom_wem;
  logic [31:0] rom_addr, rom_data;

  uart_loader #(.CLK_DIV(CLK_DIV), .BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .rstn(rstn), .boot_en_i(boot_en), .uart_rx_i(rx),
    .rom_cs_o(rom_cs), .rom_we_o(rom_we), .rom_wem_o(rom_wem),
    .rom_addr_o(rom_addr), .rom_data_o(rom_data), .core_rstn_o(core_rstn),
    .load_done_o(load_done), .load_err_o(load_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // write monitor, sampled on the falling edge
  logic [31:0] wa_q[$], wd_q[$];
  int inv_err, last_wr, done_cyc, crst_cyc;
  bit prev_we;

  task automatic clear_mon();
    wa_q.delete(); wd_q.delete();
    inv_err = 0; last_wr = -1; done_cyc = -1; crst_cyc = -1; prev_we = 0;
  endtask

  always @(negedge clk) begin
    if (rom_we) begin
      wa_q.push_back(rom_addr);
      wd_q.push_back(rom_data);
      last_wr = cyc;
      if (prev_we) inv_err++;
    end
    if (rom_cs !== rom_we || rom_wem !== (rom_we ? 4'hF : 4'h0)) inv_err++;
    if (load_done && done_cyc < 0) done_cyc = cyc;
    if (core_rstn && crst_cyc < 0) crst_cyc = cyc;
    prev_we = rom_we;
  end

  logic [7:0] tx_q[$];
  int bad_idx;

  task automatic send_bit(input logic v);
    @(negedge clk) rx = v;
    repeat (CLK_DIV-1) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    send_bit(1'b1);
  endtask

  task automatic do_reset(input logic en);
    rstn = 1'b0; rx = 1'b1; boot_en = en;
    repeat (3) @(negedge clk);
    clear_mon();
    rstn = 1'b1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cs"},   rom_cs,    0);
    chk({tag, "_we"},   rom_we,    0);
    chk({tag, "_wem"},  rom_wem,   0);
    chk({tag, "_addr"}, rom_addr,  BASE);
    chk({tag, "_data"}, rom_data,  0);
    chk({tag, "_crst"}, core_rstn, 0);
    chk({tag, "_done"}, load_done, 0);
    chk({tag, "_err"},  load_err,  0);
  endtask

  task automatic send_all();
    for (int i = 0; i < tx_q.size(); i++) send_byte(tx_q[i], (i != bad_idx));
  endtask

  task automatic wait_end(input string tag);
    int k = 0;
    while (!(load_done || load_err) && k < 400) begin
      @(negedge clk); k++;
    end
    chk({tag, "_finished"}, (load_done || load_err), 1);
    repeat (6) @(negedge clk);
  endtask

  // Image-level model: length word, then N words, truncated at any framing error
  task automatic check_model(input string tag);
    int L, nw, avail;
    logic [31:0] n, w;
    bit e_err, e_done;
    L = (bad_idx >= 0) ? bad_idx : tx_q.size();
    e_err = 0; e_done = 0; nw = 0;
    if (L < 4) e_err = (bad_idx >= 0);
    else begin
      n = {tx_q[3], tx_q[2], tx_q[1], tx_q[0]};
      if (n == 0) e_done = 1;
      else if (n > 32'(MAXW)) e_err = 1;
      else begin
        avail = (L - 4) / 4;
        nw = (int'(n) < avail) ? int'(n) : avail;
        if (nw == int'(n)) e_done = 1; else e_err = 1;
      end
    end
    chk({tag, "_done"}, load_done, e_done);
    chk({tag, "_err"},  load_err,  e_err);
    chk({tag, "_crst"}, core_rstn, e_done);
    chk({tag, "_nwr"},  wa_q.size(), nw);
    for (int i = 0; i < nw && i < wa_q.size(); i++) begin
      w = {tx_q[7+4*i], tx_q[6+4*i], tx_q[5+4*i], tx_q[4+4*i]};
      chk($sformatf("%s_addr%0d", tag, i), wa_q[i], BASE + 32'(4*i));
      chk($sformatf("%s_data%0d", tag, i), wd_q[i], w);
    end
    chk({tag, "_strobes"}, inv_err, 0);
    if (e_done && nw > 0) chk({tag, "_done_lat"}, done_cyc - last_wr, 1);
    if (e_done) chk({tag, "_crst_cyc"}, crst_cyc, done_cyc);
  endtask

  task automatic rand_image(input int n);
    tx_q.delete();
    tx_q = '{8'(n), 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 4*n; i++) tx_q.push_back(8'($urandom));
    bad_idx = -1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rstn = 1'b1;
    #2 rstn = 1'b0;
    #1 chk_reset_vals("por");

    // boot disabled: immediate release
    repeat (2) @(negedge clk);
    clear_mon();
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("skip_done", load_done, 1);
    chk("skip_crst", core_rstn, 1);
    repeat (10) @(negedge clk);
    chk("skip_nwr", wa_q.size(), 0);
    chk("skip_err", load_err, 0);

    // two-word image from the plan
    tx_q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
             8'h93, 8'h05, 8'h20, 8'h00};
    bad_idx = -1;
    do_reset(1); send_all(); wait_end("two"); check_model("two");

    tx_q = '{8'h00, 8'h00, 8'h00, 8'h00};
    do_reset(1); send_all(); wait_end("zero"); check_model("zero");

    tx_q = '{8'h01, 8'h10, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    do_reset(1); send_all(); wait_end("big"); check_model("big");

    // framing error in the middle of the second word, then more valid bytes
    rand_image(2);
    for (int i = 0; i < 4; i++) tx_q.push_back(8'($urandom));
    bad_idx = 10;
    do_reset(1); send_all(); wait_end("ferr"); check_model("ferr");

    // start-bit glitch while collecting the length
    tx_q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    bad_idx = -1;
    do_reset(1);
    repeat (3) @(negedge clk);
    rx = 1'b0;
    @(negedge clk) rx = 1'b1;
    repeat (8) @(negedge clk);
    send_all(); wait_end("glitch"); check_model("glitch");
    if (wd_q.size() > 0) chk("glitch_word", wd_q[0], 32'hDDCCBBAA);

    // reset after one written word plus two bytes of the next
    rand_image(2);
    do_reset(1);
    for (int i = 0; i < 10; i++) send_byte(tx_q[i], 1'b1);
    chk("mid_nwr", wa_q.size(), 1);
    @(negedge clk) rstn = 1'b0;
    #1 chk_reset_vals("mid_rst");
    rand_image(3);
    do_reset(1); send_all(); wait_end("reload"); check_model("reload");

    for (int t = 0; t < 4; t++) begin
      rand_image($urandom_range(1, 6));
      do_reset(1); send_all();
      wait_end($sformatf("rnd%0d", t));
      check_model($sformatf("rnd%0d", t));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
